triadic_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the triadic register-register datapath. It steps each instruction through FETCH, DECODE, EXEC and WRITEBACK. From the instruction word and the RS1-is-zero flag it drives the datapath select and enable lines: Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC and WE. It also drives the IR and PC load strobes. It sits between the step-enable source (slow-tick divider or single-step button) and the datapath, which today gets these controls from switches.

---
 rtl/triadic_ctrl_fsm.sv | 115 +++++++++++
 tb/tb_triadic_ctrl_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/triadic_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the triadic datapath.
// Optional retire counter output enabled by defining TRIADIC_CTRL_RETIRE_CNT_EN.
module triadic_ctrl_fsm #(
  parameter logic [5:0] HALT_OP = 6'h3F,
  parameter logic [5:0] J_OP    = 6'h02,
  parameter logic [5:0] JAL_OP  = 6'h03,
  parameter logic [5:0] BEQZ_OP = 6'h04,
  parameter logic [5:0] IALU_LO = 6'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [31:0] IR,
  input  logic        RS1is0,
  output logic        ir_load,
  output logic        pc_load,
  output logic        WE,
  output logic        Oprnd1Sel,
  output logic        Oprnd2Sel,
  output logic        RDSEL,
  output logic        DinSel2,
  output logic        ExtnCntl,
  output logic        NextPC,
  output logic [2:0]  state,
  output logic        halted,
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t     st;
  logic [5:0] op;
  logic       is_r, is_ialu, is_beqz, is_j, is_jal;
  logic       wb_we;
  logic       beqz_q;

  assign op    = IR[31:26];
  assign state = st;

  always_comb begin
    is_r    = (op == 6'd0);
    // 7-bit compare so an IALU_LO near the top of the opcode space cannot wrap
    is_ialu = ({1'b0, op} >= {1'b0, IALU_LO}) && ({1'b0, op} <= ({1'b0, IALU_LO} + 7'd7));
    is_beqz = (op == BEQZ_OP);
    is_j    = (op == J_OP);
    is_jal  = (op == JAL_OP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
      {ir_load, pc_load, WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC} <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      wb_we   <= 1'b0;
      beqz_q  <= 1'b0;
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
      retire_cnt <= '0;
`endif
    end else if (step) begin
      case (st)
        S_FETCH: begin
          st      <= S_DECODE;
          ir_load <= 1'b0;
        end
        S_DECODE: begin
          if (is_r || is_ialu || is_beqz || is_j || is_jal) begin
            st        <= S_EXEC;
            Oprnd1Sel <= is_beqz || is_j || is_jal;
            Oprnd2Sel <= is_ialu || is_beqz || is_j || is_jal;
            RDSEL     <= is_r;
            DinSel2   <= is_r || is_ialu;
            ExtnCntl  <= is_j || is_jal;
            NextPC    <= is_j || is_jal;
            wb_we     <= is_r || is_ialu || is_jal;
            beqz_q    <= is_beqz;
          end else begin
            st      <= S_HALT;
            halted  <= 1'b1;
            illegal <= (op != HALT_OP);
          end
        end
        S_EXEC: begin
          st      <= S_WB;
          pc_load <= 1'b1;
          WE      <= wb_we;
          if (beqz_q) NextPC <= RS1is0;
        end
        S_WB: begin
          // control word is cleared on retire so FETCH/DECODE present a quiet datapath
          st      <= S_FETCH;
          ir_load <= 1'b1;
          {pc_load, WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC} <= '0;
          wb_we   <= 1'b0;
          beqz_q  <= 1'b0;
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
          retire_cnt <= retire_cnt + 32'd1;
`endif
        end
        S_HALT: st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_triadic_ctrl_fsm.sv
// Self-checking bench for triadic_ctrl_fsm: vector table, directed corner cases,
// and randomized stimulus against a phase-counting reference model.
module tb_triadic_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, step, RS1is0;
  logic [31:0] IR;
  logic        ir_load, pc_load, WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC;
  logic        halted, illegal;
  logic [2:0]  state;
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  triadic_ctrl_fsm #(.HALT_OP(6'h3F), .J_OP(6'h02), .JAL_OP(6'h03), .BEQZ_OP(6'h04), .IALU_LO(6'h08)) dut (
    .clk(clk), .rst(rst), .step(step), .IR(IR), .RS1is0(RS1is0),
    .ir_load(ir_load), .pc_load(pc_load), .WE(WE),
    .Oprnd1Sel(Oprnd1Sel), .Oprnd2Sel(Oprnd2Sel), .RDSEL(RDSEL), .DinSel2(DinSel2),
    .ExtnCntl(ExtnCntl), .NextPC(NextPC), .state(state), .halted(halted),
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: instruction phase 0..3 counted in steps, 4 = parked
  int          m_ph;
  bit          m_fresh;
  int          m_cls;
  bit          m_br;
  bit          m_ill;
  logic [31:0] m_cnt;

  // 0=R 1=IALU 2=BEQZ 3=J 4=JAL 5=HALT 6=undefined
  function automatic int class_of(input logic [5:0] op);
    if (op == 6'h00) return 0;
    if (op >= 6'h08 && op <= 6'h0F) return 1;
    if (op == 6'h04) return 2;
    if (op == 6'h02) return 3;
    if (op == 6'h03) return 4;
    if (op == 6'h3F) return 5;
    return 6;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_ph = 0; m_fresh = 1; m_ill = 0; m_cnt = 0; m_cls = 0; m_br = 0;
    end else if (step) begin
      case (m_ph)
        0: begin m_ph = 1; m_fresh = 0; end
        1: begin
          m_cls = class_of(IR[31:26]);
          if (m_cls >= 5) begin m_ph = 4; m_ill = (m_cls == 6); end
          else m_ph = 2;
        end
        2: begin m_br = RS1is0; m_ph = 3; end
        3: begin m_ph = 0; m_cnt = m_cnt + 1; end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    bit o1, o2, rd, din, ext, npc, we, act;
    o1 = 0; o2 = 0; rd = 0; din = 0; ext = 0; npc = 0; we = 0;
    act = (m_ph == 2 || m_ph == 3);
    if (act) begin
      case (m_cls)
        0: begin rd = 1; din = 1; end
        1: begin o2 = 1; din = 1; end
        2: begin o1 = 1; o2 = 1; npc = (m_ph == 3) && m_br; end
        3, 4: begin o1 = 1; o2 = 1; ext = 1; npc = 1; end
        default: ;
      endcase
      we = (m_ph == 3) && (m_cls == 0 || m_cls == 1 || m_cls == 4);
    end
    chk("outputs",
        {18'd0, state, halted, illegal, ir_load, pc_load, WE, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC},
        {18'd0, 3'(m_ph), m_ph == 4, m_ill, (m_ph == 0) && !m_fresh, m_ph == 3, we, o1, o2, rd, din, ext, npc});
`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
    chk("retire_cnt_model", retire_cnt, m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic do_reset();
    rst = 1; step = 0; tick(); rst = 0;
  endtask

  typedef struct {
    logic [5:0] op;
    logic       rs1;
    logic [6:0] wb; // {Oprnd1Sel,Oprnd2Sel,RDSEL,DinSel2,ExtnCntl,NextPC,WE} in WB
  } vec_t;

  vec_t vecs[7];
  logic [5:0] legal_ops[7] = '{6'h00, 6'h08, 6'h0F, 6'h04, 6'h02, 6'h03, 6'h0B};
  logic [5:0] bad_ops[3]   = '{6'h3F, 6'h15, 6'h10};

  initial begin
    vecs[0] = '{6'h00, 1'b0, 7'b0011001};
    vecs[1] = '{6'h08, 1'b0, 7'b0101001};
    vecs[2] = '{6'h0F, 1'b1, 7'b0101001};
    vecs[3] = '{6'h04, 1'b1, 7'b1100010};
    vecs[4] = '{6'h04, 1'b0, 7'b1100000};
    vecs[5] = '{6'h02, 1'b0, 7'b1100110};
    vecs[6] = '{6'h03, 1'b1, 7'b1100111};
    rst = 1; step = 0; RS1is0 = 0; IR = '0;

    // reset state
    do_reset();
    chk("reset_state", {state, halted, illegal, ir_load, pc_load, WE, NextPC}, 32'h0);

    // vector table: one full instruction each, WB controls checked
    for (int i = 0; i < 7; i++) begin
      do_reset();
      IR = {vecs[i].op, 26'h0A5_1234};
      RS1is0 = vecs[i].rs1;
      step = 1;
      tick(); tick(); tick();
      chk($sformatf("vec%0d_wb", i),
          {Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, ExtnCntl, NextPC, WE, pc_load, state},
          {vecs[i].wb, 1'b1, 3'd3});
      tick();
      chk($sformatf("vec%0d_fetch", i), {state, ir_load, WE, pc_load}, {3'd0, 1'b1, 1'b0, 1'b0});
    end

    // R-type state walk with step held high
    do_reset();
    IR = 32'h0022_1820; step = 1;
    tick(); chk("rtype_s1", state, 1);
    tick(); chk("rtype_s2", state, 2);
    tick(); chk("rtype_s3", state, 3);
    chk("rtype_wb", {RDSEL, DinSel2, WE, pc_load, NextPC}, 5'b11110);
    tick(); chk("rtype_s0", state, 0);

    // undefined opcode parks the FSM
    do_reset();
    IR = {6'h15, 26'h0}; step = 1;
    tick(); tick();
    chk("illegal_halt", {state, halted, illegal}, {3'd4, 1'b1, 1'b1});
    for (int i = 0; i < 10; i++) tick();
    chk("illegal_stay", {state, halted, illegal, WE, pc_load}, {3'd4, 1'b1, 1'b1, 1'b0, 1'b0});
    rst = 1; tick(); rst = 0;
    chk("illegal_clr", {state, halted, illegal}, 5'd0);

    // stall in EXEC: everything holds
    do_reset();
    IR = 32'h0000_0020; step = 1;
    tick(); tick();
    step = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_exec", {state, Oprnd1Sel, Oprnd2Sel, RDSEL, DinSel2, WE, pc_load}, {3'd2, 6'b001100});
    end
    // reset wins over step in WB
    step = 1; tick();
    chk("pre_rst_wb", {state, WE}, {3'd3, 1'b1});
    rst = 1; tick(); rst = 0;
    chk("rst_in_wb", {state, WE, pc_load, ir_load}, 6'd0);

`ifdef TRIADIC_CTRL_RETIRE_CNT_EN
    do_reset();
    step = 1;
    for (int i = 0; i < 3; i++) begin
      IR = {legal_ops[i], 26'h0};
      for (int k = 0; k < 4; k++) tick();
    end
    IR = {6'h3F, 26'h0};
    tick(); tick();
    chk("retire_3", retire_cnt, 3);
    chk("halt_op_legal", {state, illegal}, {3'd4, 1'b0});
    for (int i = 0; i < 8; i++) tick();
    chk("retire_hold", retire_cnt, 3);
`endif

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 15);
      rst = ($urandom_range(0, 39) == 0);
      step = ($urandom_range(0, 3) != 0);
      RS1is0 = 1'($urandom_range(0, 1));
      IR = {(r < 13) ? legal_ops[r % 7] : bad_ops[r - 13], 26'($urandom)};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
